// File: rtl/write_full.sv
// Write-domain half of the asynchronous FIFO: read-pointer synchronizer, binary/Gray
// write pointers, memory write port, full/almost-full flags, occupancy and sticky overflow.
module write_full #(
    parameter int ADDRESS_BITS = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                    wclk,
    input  logic                    wrst,
    input  logic                    winc,
    input  logic                    wovf_clr,
    input  logic [ADDRESS_BITS:0]   wrptr_async,
    output logic                    wen,
    output logic [ADDRESS_BITS-1:0] waddr,
    output logic [ADDRESS_BITS:0]   wptr,
    output logic                    wfull,
    output logic                    walmost_full,
    output logic [ADDRESS_BITS:0]   wcount,
    output logic                    woverflow
);
    localparam int AB = ADDRESS_BITS;

    logic [AB:0] r_wq1;
    logic [AB:0] r_wq2;
    logic [AB:0] r_wbin;
    logic [AB:0] r_wptr;
    logic [AB:0] r_wcount;
    logic        r_wfull;
    logic        r_walmost_full;
    logic        r_woverflow;

    logic [AB:0] w_wq2_bin;
    logic [AB:0] w_wbinnext;
    logic [AB:0] w_wgraynext;
    logic [AB:0] w_diff;
    logic        w_winc_ok;
    logic        w_wfull_val;
    logic        w_afull_val;

    // Plain two-flop synchronizer: nothing may sit between the stages.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_wq1 <= '0;
            r_wq2 <= '0;
        end else begin
            // NOTE: non-blocking so r_wq2 captures the previous r_wq1, giving two real stages.
            r_wq1 <= wrptr_async;
            r_wq2 <= r_wq1;
        end
    end

    // Each binary bit is the XOR of all Gray bits from the MSB down to it.
    always_comb begin
        w_wq2_bin = '0;
        for (int i = 0; i <= AB; i++) begin
            w_wq2_bin[i] = ^(r_wq2 >> i);
        end
    end

    assign w_winc_ok   = winc & ~r_wfull;
    assign w_wbinnext  = r_wbin + {{AB{1'b0}}, w_winc_ok};
    assign w_wgraynext = (w_wbinnext >> 1) ^ w_wbinnext;
    // Full when the write pointer is exactly one lap ahead of the synced read pointer.
    assign w_wfull_val = (w_wgraynext == {~r_wq2[AB:AB-1], r_wq2[AB-2:0]});
    assign w_diff      = w_wbinnext - w_wq2_bin;
    assign w_afull_val = (w_diff >= (AB+1)'(AFULL_THRESH));

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wcount       <= '0;
        end else begin
            r_wbin         <= w_wbinnext;
            r_wptr         <= w_wgraynext;
            r_wfull        <= w_wfull_val;
            r_walmost_full <= w_afull_val;
            r_wcount       <= w_diff;
        end
    end

    // A new overflow event takes priority over a clear in the same cycle.
    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_woverflow <= 1'b0;
        end else if (winc & r_wfull) begin
            r_woverflow <= 1'b1;
        end else if (wovf_clr) begin
            r_woverflow <= 1'b0;
        end
    end

    assign wen          = w_winc_ok;
    assign waddr        = r_wbin[AB-1:0];
    assign wptr         = r_wptr;
    assign wfull        = r_wfull;
    assign walmost_full = r_walmost_full;
    assign wcount       = r_wcount;
    assign woverflow    = r_woverflow;

endmodule

// File: tb/tb_write_full.sv
// Bench for write_full: a vector table for fill/overflow/drain/simultaneous cases,
// then reset, wrap-around and random traffic checked against a cycle model via a queue.
module tb_write_full;
    localparam int AB = 4;

    logic          wclk = 1'b0;
    logic          wrst;
    logic          winc;
    logic          wovf_clr;
    logic [AB:0]   wrptr_async;
    logic          wen;
    logic [AB-1:0] waddr;
    logic [AB:0]   wptr;
    logic          wfull;
    logic          walmost_full;
    logic [AB:0]   wcount;
    logic          woverflow;

    write_full #(.ADDRESS_BITS(AB), .AFULL_THRESH(12)) dut (
        .wclk(wclk), .wrst(wrst), .winc(winc), .wovf_clr(wovf_clr),
        .wrptr_async(wrptr_async), .wen(wen), .waddr(waddr), .wptr(wptr),
        .wfull(wfull), .walmost_full(walmost_full), .wcount(wcount),
        .woverflow(woverflow)
    );

    always #5 wclk = ~wclk;

    typedef struct {
        logic       winc;
        logic       clr;
        logic [4:0] rgray;
        logic       exp_wen;
        logic [4:0] exp_wptr;
        logic       exp_full;
        logic       exp_afull;
        logic [4:0] exp_cnt;
        logic       exp_ovf;
    } vec_t;

    typedef struct {
        logic [4:0] wptr;
        logic       full;
        logic       afull;
        logic [4:0] cnt;
        logic       ovf;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[27];
    vec_t dummy;
    int   total = 0;
    int   bad   = 0;

    int m_wbin, m_q1, m_q2, m_full, m_ovf, m_total;

    function automatic logic [4:0] gray(input int b);
        logic [4:0] x;
        x = 5'(b);
        return x ^ (x >> 1);
    endfunction

    function automatic int g2b(input logic [4:0] g);
        int b;
        b = int'(g);
        b = b ^ (b >> 1);
        b = b ^ (b >> 2);
        b = b ^ (b >> 4);
        return b;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_wbin = 0; m_q1 = 0; m_q2 = 0; m_full = 0; m_ovf = 0; m_total = 0;
    endtask

    task automatic model_step(input bit wi, input bit ci, input int rg, output exp_t e);
        int acc, nb, occ;
        acc = (wi && m_full == 0) ? 1 : 0;
        nb  = (m_wbin + acc) & 31;
        occ = (nb - g2b(5'(m_q2))) & 31;
        e.wptr  = gray(nb);
        e.full  = (occ == 16);
        e.afull = (occ >= 12);
        e.cnt   = 5'(occ);
        e.ovf   = (wi && m_full != 0) ? 1'b1 : (ci ? 1'b0 : (m_ovf != 0));
        m_full  = e.full ? 1 : 0;
        m_ovf   = e.ovf ? 1 : 0;
        m_q2    = m_q1;
        m_q1    = rg;
        m_wbin  = nb;
        m_total += acc;
    endtask

    // One clock: drive, check the write port before the edge, queue the expected
    // registered outputs, then pop and compare just after the edge.
    task automatic cycle(input logic wi, input logic ci, input logic [4:0] rg,
                         input bit has_ref, input vec_t v, input string name);
        exp_t e, got;
        winc        = wi;
        wovf_clr    = ci;
        wrptr_async = rg;
        #1;
        check({name, ".wen"}, wen, has_ref ? v.exp_wen : ((wi && m_full == 0) ? 1'b1 : 1'b0));
        check({name, ".waddr"}, waddr, m_wbin & 15);
        model_step(wi, ci, int'(rg), e);
        if (has_ref) begin
            e.wptr = v.exp_wptr; e.full = v.exp_full; e.afull = v.exp_afull;
            e.cnt  = v.exp_cnt;  e.ovf  = v.exp_ovf;
        end
        sb_q.push_back(e);
        @(posedge wclk);
        #1;
        got = sb_q.pop_front();
        check({name, ".wptr"}, wptr, got.wptr);
        check({name, ".wfull"}, wfull, got.full);
        check({name, ".walmost_full"}, walmost_full, got.afull);
        check({name, ".wcount"}, wcount, got.cnt);
        check({name, ".woverflow"}, woverflow, got.ovf);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [4:0] prev;
        bit         saw_wrap;
        int         rd;
        logic       wi, ci;

        dummy = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0};
        for (int i = 0; i < 16; i++)
            tbl[i] = '{1'b1, 1'b0, 5'd0, 1'b1, gray(i + 1), (i == 15), (i + 1 >= 12), 5'(i + 1), 1'b0};
        tbl[16] = '{1'b1, 1'b0, 5'b00000, 1'b0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1};
        tbl[17] = '{1'b1, 1'b1, 5'b00000, 1'b0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b1};
        tbl[18] = '{1'b0, 1'b1, 5'b00000, 1'b0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0};
        tbl[19] = '{1'b0, 1'b0, 5'b00110, 1'b0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0};
        tbl[20] = '{1'b0, 1'b0, 5'b00110, 1'b0, 5'b11000, 1'b1, 1'b1, 5'd16, 1'b0};
        tbl[21] = '{1'b0, 1'b0, 5'b00110, 1'b0, 5'b11000, 1'b0, 1'b1, 5'd12, 1'b0};
        tbl[22] = '{1'b1, 1'b0, 5'b00110, 1'b1, 5'b11001, 1'b0, 1'b1, 5'd13, 1'b0};
        tbl[23] = '{1'b1, 1'b0, 5'b00110, 1'b1, 5'b11011, 1'b0, 1'b1, 5'd14, 1'b0};
        tbl[24] = '{1'b1, 1'b0, 5'b00111, 1'b1, 5'b11010, 1'b0, 1'b1, 5'd15, 1'b0};
        tbl[25] = '{1'b0, 1'b0, 5'b00111, 1'b0, 5'b11010, 1'b0, 1'b1, 5'd15, 1'b0};
        tbl[26] = '{1'b1, 1'b0, 5'b00111, 1'b1, 5'b11110, 1'b0, 1'b1, 5'd15, 1'b0};

        wrst = 1'b1; winc = 1'b0; wovf_clr = 1'b0; wrptr_async = '0;
        model_reset();
        repeat (2) @(posedge wclk);
        #1;
        check("reset.wptr", wptr, 0);
        check("reset.wcount", wcount, 0);
        check("reset.flags", {wfull, walmost_full, woverflow, wen}, 0);
        @(negedge wclk);
        wrst = 1'b0;

        for (int i = 0; i < 27; i++)
            cycle(tbl[i].winc, tbl[i].clr, tbl[i].rgray, 1'b1, tbl[i], $sformatf("vec%0d", i));

        // Asynchronous reset in the middle of a burst, between clock edges.
        winc = 1'b1; wovf_clr = 1'b0;
        #2 wrst = 1'b1;
        #1;
        check("midrst.wptr", wptr, 0);
        check("midrst.wcount", wcount, 0);
        check("midrst.wfull", wfull, 0);
        check("midrst.walmost_full", walmost_full, 0);
        check("midrst.woverflow", woverflow, 0);
        check("midrst.wen", wen, 1);
        check("midrst.waddr", waddr, 0);
        model_reset();
        wrptr_async = '0;
        @(posedge wclk);
        @(negedge wclk);
        wrst = 1'b0;
        #1;
        check("release.waddr", waddr, 0);

        // Wrap-around with the reader trailing two writes behind.
        prev = wptr;
        saw_wrap = 1'b0;
        for (int k = 0; k < 40; k++) begin
            rd = (k >= 2) ? k - 2 : 0;
            cycle(1'b1, 1'b0, gray(rd), 1'b0, dummy, $sformatf("wrap%0d", k));
            check($sformatf("wrap%0d.gray_step", k), $countones(prev ^ wptr), 1);
            if (prev == 5'b10000 && wptr == 5'b00000) saw_wrap = 1'b1;
            prev = wptr;
        end
        check("wrap.seen_31_to_0", saw_wrap, 1);

        // Random traffic; the reader never passes what has been written.
        rd = m_total - 2;
        for (int k = 0; k < 150; k++) begin
            wi = ($urandom_range(0, 3) != 0);
            ci = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0 && rd < m_total)
                rd += $urandom_range(1, (m_total - rd > 3) ? 3 : m_total - rd);
            cycle(wi, ci, gray(rd & 31), 1'b0, dummy, $sformatf("rand%0d", k));
        end

        check("scoreboard.empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
